// File: rtl/spinn_aer_if_cfg_pkg.sv
// Shared definitions for the SpiNNaker<->AER configuration controller:
// packet field positions, opcodes, packet type code and FSM states.
package spinn_aer_if_cfg_pkg;

  localparam int PKT_BITS    = 72;
  localparam int PKT_PAR     = 0;
  localparam int PKT_PFLAG   = 1;
  localparam int PKT_TYPE_LO = 6;
  localparam int PKT_TYPE_HI = 7;
  localparam int PKT_KEY_LO  = 8;
  localparam int PKT_KEY_HI  = 39;
  localparam int PKT_PLD_LO  = 40;
  localparam int PKT_PLD_HI  = 71;

  localparam logic [1:0] PKT_TYPE_MC = 2'b00;

  localparam logic [3:0] CFG_OP_GO   = 4'd0;
  localparam logic [3:0] CFG_OP_VKEY = 4'd1;
  localparam logic [3:0] CFG_OP_MODE = 4'd2;
  localparam logic [3:0] CFG_OP_STAT = 4'd3;
  localparam logic [3:0] CFG_OP_CLR  = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_REPLY = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/spinn_aer_if_cfg_ctrl_parity.sv
// Odd-parity reduction over a SpiNNaker packet; the payload flag selects
// whether the 32-bit payload field takes part.
module spinn_pkt_parity
  import spinn_aer_if_cfg_pkg::*;
(
  input  logic [PKT_BITS-1:0] pkt,
  input  logic                pflag,
  output logic                odd
);

  always_comb begin
    odd = pflag ? ^pkt : ^pkt[PKT_KEY_HI:0];
  end

endmodule

// File: rtl/spinn_aer_if_cfg_ctrl.sv
// Configuration controller: validates incoming multicast config packets,
// executes one command per packet and answers status reads with a reply.
module spinn_aer_if_cfg_ctrl
  import spinn_aer_if_cfg_pkg::*;
#(
  parameter int          MODE_BITS = 3,
  parameter int          VKEY_BITS = 16,
  parameter logic [31:0] CFG_KEY   = 32'hFFFF_FE00,
  parameter logic [31:0] CFG_MASK  = 32'hFFFF_FFF0,
  parameter logic [31:0] RPLY_KEY  = 32'hFFFF_FD00,
  parameter logic        INIT_GO   = 1'b0,
  parameter logic [VKEY_BITS-1:0] INIT_VKEY = 16'h0200,
  parameter logic [MODE_BITS-1:0] INIT_MODE = 3'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PKT_BITS-1:0]  cpkt_data,
  input  logic                 cpkt_vld,
  output logic                 cpkt_rdy,
  output logic [PKT_BITS-1:0]  rpkt_data,
  output logic                 rpkt_vld,
  input  logic                 rpkt_rdy,
  output logic                 go,
  output logic [VKEY_BITS-1:0] vkey,
  output logic [MODE_BITS-1:0] vmode,
  output logic [7:0]           perr_cnt
);

  cfg_state_e          state_q, state_d;
  logic [PKT_BITS-1:0] pkt_q;
  logic                rx_odd;
  logic                pflag;
  logic                key_hit;
  logic                type_mc;
  logic [3:0]          op;
  logic                upd_go, upd_vkey, upd_mode, perr_inc, perr_clr;
  logic                rply_load, rply_done;
  logic [31:0]         rply_pld;
  logic [PKT_BITS-1:0] rply_raw, rply_pkt;
  logic                rply_odd;

  assign pflag   = pkt_q[PKT_PFLAG];
  assign key_hit = (pkt_q[PKT_KEY_HI:PKT_KEY_LO] & CFG_MASK) == CFG_KEY;
  assign type_mc = pkt_q[PKT_TYPE_HI:PKT_TYPE_LO] == PKT_TYPE_MC;
  assign op      = pkt_q[PKT_KEY_LO +: 4];

  spinn_pkt_parity u_rx_par (
    .pkt   (pkt_q),
    .pflag (pflag),
    .odd   (rx_odd)
  );

  // Reply built from the live registers so the EXEC edge samples them.
  always_comb begin
    rply_pld        = '0;
    rply_pld[15:0]  = 16'(vkey);
    rply_pld[23:16] = perr_cnt;
    rply_pld[26:24] = 3'(vmode);
    rply_pld[31]    = go;
    rply_raw                           = '0;
    rply_raw[PKT_PLD_HI:PKT_PLD_LO]    = rply_pld;
    rply_raw[PKT_KEY_HI:PKT_KEY_LO]    = RPLY_KEY;
    rply_raw[PKT_TYPE_HI:PKT_TYPE_LO]  = PKT_TYPE_MC;
    rply_raw[PKT_PFLAG]                = 1'b1;
  end

  spinn_pkt_parity u_tx_par (
    .pkt   (rply_raw),
    .pflag (1'b1),
    .odd   (rply_odd)
  );

  always_comb begin
    rply_pkt          = rply_raw;
    rply_pkt[PKT_PAR] = ~rply_odd;
  end

  always_comb begin
    state_d   = state_q;
    upd_go    = 1'b0;
    upd_vkey  = 1'b0;
    upd_mode  = 1'b0;
    perr_inc  = 1'b0;
    perr_clr  = 1'b0;
    rply_load = 1'b0;
    rply_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpkt_vld && cpkt_rdy) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (!rx_odd) begin
          perr_inc = 1'b1;
        end else if (key_hit && type_mc) begin
          case (op)
            CFG_OP_GO:   upd_go   = 1'b1;
            CFG_OP_VKEY: upd_vkey = pflag;
            CFG_OP_MODE: upd_mode = pflag;
            CFG_OP_STAT: begin
              rply_load = 1'b1;
              state_d   = ST_REPLY;
            end
            CFG_OP_CLR:  perr_clr = 1'b1;
            default: ;
          endcase
        end
      end
      ST_REPLY: begin
        if (rpkt_rdy) begin
          rply_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cpkt_rdy <= 1'b0;
    end else begin
      state_q  <= state_d;
      cpkt_rdy <= (state_d == ST_IDLE);
    end
  end

  // Packet capture and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q     <= '0;
      go        <= INIT_GO;
      vkey      <= INIT_VKEY;
      vmode     <= INIT_MODE;
      perr_cnt  <= 8'd0;
      rpkt_vld  <= 1'b0;
      rpkt_data <= '0;
    end else begin
      if (state_q == ST_IDLE && cpkt_vld && cpkt_rdy) pkt_q <= cpkt_data;
      if (upd_go)   go    <= pkt_q[PKT_PLD_LO];
      if (upd_vkey) vkey  <= pkt_q[PKT_PLD_LO +: VKEY_BITS];
      if (upd_mode) vmode <= pkt_q[PKT_PLD_LO +: MODE_BITS];
      if (perr_clr) begin
        perr_cnt <= 8'd0;
      end else if (perr_inc && perr_cnt != 8'hFF) begin
        perr_cnt <= perr_cnt + 8'd1;
      end
      if (rply_load) begin
        rpkt_data <= rply_pkt;
        rpkt_vld  <= 1'b1;
      end else if (rply_done) begin
        rpkt_vld  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spinn_aer_if_cfg_ctrl.sv
// Directed bench for the configuration controller with hand-computed expectations.
module tb_spinn_aer_if_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] cpkt_data;
  logic        cpkt_vld;
  logic        cpkt_rdy;
  logic [71:0] rpkt_data;
  logic        rpkt_vld;
  logic        rpkt_rdy;
  logic        go;
  logic [15:0] vkey;
  logic [2:0]  vmode;
  logic [7:0]  perr_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  spinn_aer_if_cfg_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpkt_data (cpkt_data),
    .cpkt_vld  (cpkt_vld),
    .cpkt_rdy  (cpkt_rdy),
    .rpkt_data (rpkt_data),
    .rpkt_vld  (rpkt_vld),
    .rpkt_rdy  (rpkt_rdy),
    .go        (go),
    .vkey      (vkey),
    .vmode     (vmode),
    .perr_cnt  (perr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // MC packet with odd parity over the flag-selected width.
  function automatic logic [71:0] mkpkt(input logic [31:0] key, input logic [31:0] pld,
                                        input logic pf);
    logic [71:0] p;
    p = {pld, key, 2'b00, 4'b0000, pf, 1'b0};
    if (pf) p[0] = ~(^p);
    else    p[0] = ~(^p[39:0]);
    return p;
  endfunction

  // Waits for ready, transfers one packet, returns #1 after the accepting edge.
  task automatic send(input logic [71:0] p);
    int n;
    n = 0;
    @(negedge clk);
    while (!cpkt_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cpkt_rdy) chk("rdy_timeout", 1'b0, 1'b1);
    cpkt_data = p;
    cpkt_vld  = 1'b1;
    @(posedge clk);
    #1;
    cpkt_vld  = 1'b0;
  endtask

  task automatic exec_pkt(input logic [71:0] p);
    send(p);
    @(posedge clk);
    #1;
  endtask

  logic [71:0] bad, rexp, held;

  initial begin
    rst_n     = 1'b0;
    cpkt_data = '0;
    cpkt_vld  = 1'b0;
    rpkt_rdy  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go", go, 1'b0);
    chk("rst_vkey", vkey, 16'h0200);
    chk("rst_vmode", vmode, 3'd0);
    chk("rst_perr", perr_cnt, 8'd0);
    chk("rst_rvld", rpkt_vld, 1'b0);
    chk("rst_rdata", rpkt_data, 72'd0);
    chk("rst_crdy", cpkt_rdy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("crdy_after_rst", cpkt_rdy, 1'b1);

    // go: still old value after accept edge, new value after EXEC edge
    send(mkpkt(32'hFFFF_FE00, 32'h1, 1'b1));
    chk("go_accept_edge", go, 1'b0);
    chk("crdy_in_exec", cpkt_rdy, 1'b0);
    @(posedge clk);
    #1;
    chk("go_set", go, 1'b1);
    chk("crdy_back", cpkt_rdy, 1'b1);

    exec_pkt(mkpkt(32'hFFFF_FE01, 32'h0000_1234, 1'b1));
    chk("vkey_set", vkey, 16'h1234);
    exec_pkt(mkpkt(32'hFFFF_FE01, 32'h0000_5678, 1'b0));
    chk("vkey_noflag", vkey, 16'h1234);

    bad = mkpkt(32'hFFFF_FE02, 32'h5, 1'b1);
    bad[40] = ~bad[40];
    exec_pkt(bad);
    chk("vmode_badpar", vmode, 3'd0);
    chk("perr_one", perr_cnt, 8'd1);
    for (int i = 0; i < 300; i++) exec_pkt(bad);
    chk("perr_sat", perr_cnt, 8'hFF);
    exec_pkt(mkpkt(32'hFFFF_FE02, 32'h5, 1'b1));
    chk("vmode_set", vmode, 3'd5);

    // status read under backpressure; a packet offered meanwhile is ignored
    rpkt_rdy = 1'b0;
    exec_pkt(mkpkt(32'hFFFF_FE03, 32'h0, 1'b1));
    rexp = mkpkt(32'hFFFF_FD00, 32'h85FF_1234, 1'b1);
    chk("rply_vld", rpkt_vld, 1'b1);
    chk("rply_data", rpkt_data, rexp);
    chk("rply_parity", ^rpkt_data, 1'b1);
    held = rexp;
    cpkt_data = mkpkt(32'hFFFF_FE00, 32'h0, 1'b1);
    cpkt_vld  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("stall_vld", rpkt_vld, 1'b1);
      chk("stall_data", rpkt_data, held);
      chk("stall_crdy", cpkt_rdy, 1'b0);
    end
    cpkt_vld = 1'b0;
    rpkt_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("rply_done_vld", rpkt_vld, 1'b0);
    chk("rply_done_crdy", cpkt_rdy, 1'b1);
    chk("go_ignored", go, 1'b1);

    exec_pkt(mkpkt(32'hFFFF_FE04, 32'h0, 1'b1));
    chk("perr_clr", perr_cnt, 8'd0);

    exec_pkt(mkpkt(32'hFFFF_FF00, 32'h0, 1'b1));
    chk("nomatch_go", go, 1'b1);
    chk("nomatch_rvld", rpkt_vld, 1'b0);
    chk("nomatch_crdy", cpkt_rdy, 1'b1);
    exec_pkt(mkpkt(32'hFFFF_FE0A, 32'h0000_0007, 1'b1));
    chk("opA_vkey", vkey, 16'h1234);
    chk("opA_vmode", vmode, 3'd5);
    chk("opA_rvld", rpkt_vld, 1'b0);
    chk("opA_crdy", cpkt_rdy, 1'b1);

    // reset while a reply is pending
    rpkt_rdy = 1'b0;
    exec_pkt(mkpkt(32'hFFFF_FE03, 32'h0, 1'b1));
    chk("rst2_pre_vld", rpkt_vld, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_vld", rpkt_vld, 1'b0);
    chk("rst2_go", go, 1'b0);
    chk("rst2_vkey", vkey, 16'h0200);
    chk("rst2_vmode", vmode, 3'd0);
    chk("rst2_perr", perr_cnt, 8'd0);
    chk("rst2_rdata", rpkt_data, 72'd0);
    chk("rst2_crdy", cpkt_rdy, 1'b0);
    rpkt_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst2_crdy_up", cpkt_rdy, 1'b1);
    exec_pkt(mkpkt(32'hFFFF_FE00, 32'h1, 1'b1));
    chk("rst2_go_set", go, 1'b1);
    chk("rst2_rvld_idle", rpkt_vld, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
